// File: rtl/mfp_ahb_lite_byte_ram_pkg.sv
// Shared AHB-Lite encodings, FSM state type and lane-strobe helpers for the
// mfp_ahb_lite_byte_ram slave.
package mfp_ahb_lite_byte_ram_pkg;

    // Transfer type encodings (HTRANS)
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Transfer size encodings (HSIZE)
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Response encodings (HRESP)
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Slave FSM: ST_IDLE covers both idle and a normal zero-wait data phase
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } state_e;

    // A transfer is legal when its size is supported and naturally aligned
    function automatic logic size_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian byte-lane strobes for a (legal) transfer
    function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_byte_ram_ram.sv
// mfp_byte_enable_ram: synchronous 32-bit RAM with four byte write enables.
// One write address and one read address per cycle; a read of the word being
// written in the same cycle returns the old contents (read-old-data).
module mfp_byte_enable_ram #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [31:0]           rdata_o,
    input  logic [3:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]           wdata_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes into the storage array
    // NOTE: the array has no reset branch so it maps onto block RAM; only the
    // small output register below is reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Registered read port; returns zero after reset until the first read
    // NOTE: non-blocking assignment here is what gives read-old-data on a
    // same-word write, since both blocks sample mem_q before either updates.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= 32'd0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mfp_ahb_lite_byte_ram.sv
// mfp_ahb_lite_byte_ram: AHB-Lite RAM slave for byte/halfword/word transfers,
// zero-wait reads and writes, two-cycle ERROR response for illegal transfers.
// Optional feature macro: MFP_AHB_RAM_FORWARD_EN -- when defined, a read that
// hits the word written in the previous data phase is served by merging the
// registered write bytes over the RAM output; otherwise it takes one STALL cycle.
module mfp_ahb_lite_byte_ram
    import mfp_ahb_lite_byte_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    // Burst type, protection, lock, the SEQ/NONSEQ distinction and the
    // address bits above the RAM size carry no meaning for this slave.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic                  accept;
    logic                  legal;
    logic [3:0]            strb;
    logic                  rd_accept;

    state_e state_q;
    logic   hreadyout_q;
    logic   hresp_q;

    assign haddr_word = HADDR[ADDR_WIDTH+1:2];
    // While this slave holds HREADYOUT low the master keeps the address
    // stable, so nothing is accepted until the current data phase ends.
    assign accept     = HSEL & HREADY & HTRANS[1] & hreadyout_q;
    assign legal      = size_legal(HSIZE, HADDR[1:0]);
    assign strb       = lane_strobe(HSIZE, HADDR[1:0]);
    assign rd_accept  = accept & legal & ~HWRITE;

    // ------------------------------------------------------------------
    // Data-phase registers
    // ------------------------------------------------------------------
    logic                  wr_pend_q;
    logic [ADDR_WIDTH-1:0] dp_addr_q;
    logic [3:0]            dp_strb_q;

    // Capture address, strobes and write intent of each accepted transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend_q <= 1'b0;
            dp_addr_q <= '0;
            dp_strb_q <= 4'b0000;
        end else if (accept) begin
            wr_pend_q <= HWRITE & legal;
            dp_addr_q <= haddr_word;
            dp_strb_q <= strb;
        end else begin
            // A write data phase is always a single zero-wait cycle
            wr_pend_q <= 1'b0;
        end
    end

    // A read address phase overlapping a write data phase to the same word:
    // the RAM commits the write at the end of this cycle and would return
    // the old word to the read.
    logic hazard;
    logic stall_req;

    assign hazard = rd_accept & wr_pend_q & (haddr_word == dp_addr_q);

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;

    // Read port: address phase normally, registered address on a stall re-read
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        ram_re    = rd_accept;
        ram_raddr = haddr_word;
        if (state_q == ST_STALL) begin
            ram_re    = 1'b1;
            ram_raddr = dp_addr_q;
        end
    end

    assign ram_we = wr_pend_q ? dp_strb_q : 4'b0000;

    mfp_byte_enable_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (HCLK),
        .rst_n_i (HRESETn),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata),
        .we_i    (ram_we),
        .waddr_i (dp_addr_q),
        .wdata_i (HWDATA)
    );

    // ------------------------------------------------------------------
    // Hazard resolution
    // ------------------------------------------------------------------
`ifdef MFP_AHB_RAM_FORWARD_EN
    logic [31:0] fwd_data_q;
    logic [3:0]  fwd_strb_q;
    logic        fwd_hit_q;

    assign stall_req = 1'b0;

    // Remember the last write's bytes and whether the next read data phase
    // must take them in place of the stale RAM output
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_data_q <= 32'd0;
            fwd_strb_q <= 4'b0000;
            fwd_hit_q  <= 1'b0;
        end else begin
            fwd_hit_q <= hazard;
            if (wr_pend_q) begin
                fwd_data_q <= HWDATA;
                fwd_strb_q <= dp_strb_q;
            end
        end
    end

    // Per-lane merge of forwarded write bytes over the RAM output
    always_comb begin
        HRDATA = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_hit_q && fwd_strb_q[i]) begin
                HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
            end
        end
    end
`else
    assign stall_req = hazard;
    assign HRDATA    = ram_rdata;
`endif

    // ------------------------------------------------------------------
    // Response FSM with registered HREADYOUT / HRESP
    // ------------------------------------------------------------------
    // Sequence normal, stall and two-cycle error responses
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR2: begin
                    if (accept && !legal) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else if (stall_req) begin
                        state_q     <= ST_STALL;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_OKAY;
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_STALL: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule
